// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies OAM_BYTES bytes from {FF46 value, idx} into sprite
// attribute memory, one byte per M-cycle, and drives the OAM lock for the sprite unit.
module oam_dma_ctrl #(
  parameter int OAM_BYTES  = 160,
  parameter int SETUP_MCYC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_m,
  input  logic        reg_sel,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        dma_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_rd_data,
  output logic        dma_active,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_di
);

  localparam int SCW = (SETUP_MCYC < 2) ? 1 : $clog2(SETUP_MCYC + 1);
  localparam logic [7:0]     LAST_IDX   = 8'(OAM_BYTES - 1);
  localparam logic [SCW-1:0] SETUP_LOAD = SCW'(SETUP_MCYC);
  localparam logic [SCW-1:0] SETUP_ONE  = SCW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [SCW-1:0] setup_cnt_q, setup_cnt_d;
  logic           restart_q, restart_d;
  logic           wr_pend_q, wr_pend_d;
  logic [7:0]     cpu_do_q, cpu_do_d;
  logic [7:0]     src_hi_q, src_hi_d;
  logic [7:0]     oam_addr_q, oam_addr_d;
  logic [7:0]     oam_di_q, oam_di_d;
  logic           dma_rd_q, dma_rd_d;
  logic           dma_active_q, dma_active_d;

  logic wr_acc;

  assign wr_acc = ce_m & reg_sel & cpu_wr;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    setup_cnt_d = setup_cnt_q;
    restart_d   = restart_q;
    wr_pend_d   = 1'b0;
    cpu_do_d    = cpu_do_q;
    src_hi_d    = src_hi_q;
    oam_addr_d  = oam_addr_q;
    oam_di_d    = oam_di_q;

    if (ce_m) begin
      case (state_q)
        ST_SETUP: begin
          if (setup_cnt_q <= SETUP_ONE) begin
            state_d     = ST_XFER;
            setup_cnt_d = '0;
            idx_d       = '0;
            restart_d   = 1'b0;
          end else begin
            setup_cnt_d = setup_cnt_q - SETUP_ONE;
          end
        end
        ST_XFER: begin
          oam_di_d   = dma_rd_data;
          oam_addr_d = idx_q;
          wr_pend_d  = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: ;
      endcase

      // A write overrides the sequencing above but keeps any capture made this M-cycle.
      if (wr_acc) begin
        state_d     = ST_SETUP;
        setup_cnt_d = SETUP_LOAD;
        idx_d       = '0;
        restart_d   = (state_q == ST_XFER) | ((state_q == ST_SETUP) & restart_q);
        cpu_do_d    = cpu_di;
        src_hi_d    = (cpu_di >= 8'hE0) ? (cpu_di - 8'h20) : cpu_di;
      end
    end

    dma_rd_d     = (state_d == ST_XFER);
    dma_active_d = (state_d == ST_XFER) | wr_pend_d | ((state_d == ST_SETUP) & restart_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      setup_cnt_q  <= '0;
      restart_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      cpu_do_q     <= '0;
      src_hi_q     <= '0;
      oam_addr_q   <= '0;
      oam_di_q     <= '0;
      dma_rd_q     <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      setup_cnt_q  <= setup_cnt_d;
      restart_q    <= restart_d;
      wr_pend_q    <= wr_pend_d;
      cpu_do_q     <= cpu_do_d;
      src_hi_q     <= src_hi_d;
      oam_addr_q   <= oam_addr_d;
      oam_di_q     <= oam_di_d;
      dma_rd_q     <= dma_rd_d;
      dma_active_q <= dma_active_d;
    end
  end

  assign cpu_do       = cpu_do_q;
  assign dma_rd       = dma_rd_q;
  assign dma_src_addr = {src_hi_q, idx_q};
  assign dma_active   = dma_active_q;
  assign oam_wr       = wr_pend_q;
  assign oam_addr     = oam_addr_q;
  assign oam_di       = oam_di_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: timeline reference model checked every clock, directed
// transfer table, restart/reset/ce_m corner sequences and randomized FF46 traffic.
module tb_oam_dma_ctrl;

  localparam int OAM_BYTES  = 160;
  localparam int SETUP_MCYC = 1;

  logic        clk;
  logic        reset_n;
  logic        ce_m;
  logic        reg_sel;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        dma_rd;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_rd_data;
  logic        dma_active;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_di;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  oam_dma_ctrl #(.OAM_BYTES(OAM_BYTES), .SETUP_MCYC(SETUP_MCYC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce_m         (ce_m),
    .reg_sel      (reg_sel),
    .cpu_wr       (cpu_wr),
    .cpu_di       (cpu_di),
    .cpu_do       (cpu_do),
    .dma_rd       (dma_rd),
    .dma_src_addr (dma_src_addr),
    .dma_rd_data  (dma_rd_data),
    .dma_active   (dma_active),
    .oam_wr       (oam_wr),
    .oam_addr     (oam_addr),
    .oam_di       (oam_di)
  );

  // Bus model: data depends on both address bytes so the source page is visible in OAM.
  assign dma_rd_data = dma_src_addr[7:0] ^ dma_src_addr[15:8];

  typedef enum int {M_IDLE, M_SETUP, M_XFER} mphase_e;

  // Reference model: a transfer is a timeline anchored at the M-cycle edge of the last write.
  int         n_edges;
  int         wr_edge;
  bit         have_wr;
  bit         lock_setup;
  bit         pend;
  int         pend_addr;
  logic [7:0] pend_data;
  logic [7:0] hi;

  int errors;
  int checks;
  int wr_cnt;
  int first_src;
  int last_src;
  int rd_cnt [256];
  bit watch_act;
  bit act_dropped;
  logic [7:0] mem [OAM_BYTES];
  bit written [OAM_BYTES];

  typedef struct {
    logic [7:0] di;
    logic [7:0] exp_hi;
    logic [7:0] exp_do;
    int         gap_at;
  } vec_t;

  vec_t tv [6];

  function automatic logic [7:0] fold(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  function automatic int xfer_pos();
    return n_edges - wr_edge - SETUP_MCYC;
  endfunction

  function automatic mphase_e model_phase();
    if (!have_wr) return M_IDLE;
    if (xfer_pos() < 0) return M_SETUP;
    if (xfer_pos() < OAM_BYTES) return M_XFER;
    return M_IDLE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edges    = 0;
    wr_edge    = 0;
    have_wr    = 1'b0;
    lock_setup = 1'b0;
    pend       = 1'b0;
    pend_addr  = 0;
    pend_data  = 8'h00;
    hi         = 8'h00;
  endtask

  task automatic model_edge(input bit ce, input bit acc, input logic [7:0] di);
    mphase_e ph;
    int k;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pend = 1'b0;
    if (!ce) return;
    ph = model_phase();
    k  = xfer_pos();
    if (ph == M_XFER) begin
      pend      = 1'b1;
      pend_addr = k;
      pend_data = 8'(k) ^ fold(hi);
    end
    if (acc) begin
      lock_setup = (ph == M_XFER) || ((ph == M_SETUP) && lock_setup);
      wr_edge    = n_edges + 1;
      have_wr    = 1'b1;
      hi         = di;
    end
    n_edges++;
  endtask

  task automatic check_outputs();
    mphase_e ph;
    int k;
    logic exp_rd;
    logic exp_act;
    ph      = model_phase();
    k       = xfer_pos();
    exp_rd  = (ph == M_XFER);
    exp_act = exp_rd | pend | ((ph == M_SETUP) & lock_setup);
    chk("dma_rd", dma_rd, exp_rd);
    chk("dma_active", dma_active, exp_act);
    chk("oam_wr", oam_wr, pend);
    chk("cpu_do", cpu_do, hi);
    if (exp_rd) chk("dma_src_addr", dma_src_addr, {fold(hi), 8'(k)});
    if (pend) begin
      chk("oam_addr", oam_addr, pend_addr);
      chk("oam_di", oam_di, pend_data);
    end
    if (oam_wr === 1'b1) begin
      wr_cnt++;
      if (oam_addr < OAM_BYTES) begin
        mem[oam_addr]     = oam_di;
        written[oam_addr] = 1'b1;
      end
    end
    if (dma_rd === 1'b1) begin
      if (first_src < 0) first_src = int'(dma_src_addr);
      last_src = int'(dma_src_addr);
    end
    if (watch_act && dma_active !== 1'b1) act_dropped = 1'b1;
  endtask

  task automatic tick(input bit ce, input bit sel, input bit wr, input logic [7:0] di);
    ce_m    = ce;
    reg_sel = sel;
    cpu_wr  = wr;
    cpu_di  = di;
    if (ce && dma_rd === 1'b1) rd_cnt[dma_src_addr[15:8]]++;
    @(posedge clk);
    model_edge(ce, sel & wr, di);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_do"}, cpu_do, 0);
    chk({tag, "_dma_rd"}, dma_rd, 0);
    chk({tag, "_dma_src_addr"}, dma_src_addr, 0);
    chk({tag, "_dma_active"}, dma_active, 0);
    chk({tag, "_oam_wr"}, oam_wr, 0);
    chk({tag, "_oam_addr"}, oam_addr, 0);
    chk({tag, "_oam_di"}, oam_di, 0);
  endtask

  // Asserts reset between clock edges; an FF46 write is held on the bus the whole time.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst");
    model_reset();
    ce_m    = 1'b1;
    reg_sel = 1'b1;
    cpu_wr  = 1'b1;
    cpu_di  = 8'hAB;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_oam_wr", oam_wr, 0);
      chk("rst_hold_cpu_do", cpu_do, 0);
    end
    reg_sel = 1'b0;
    cpu_wr  = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic clear_stats();
    wr_cnt      = 0;
    first_src   = -1;
    last_src    = -1;
    watch_act   = 1'b0;
    act_dropped = 1'b0;
    foreach (rd_cnt[i]) rd_cnt[i] = 0;
    foreach (written[i]) written[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: time %0t, required finish before 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w0;
    logic [15:0] src0;
    bit   rce;
    int   r;
    logic [7:0] rdi;
    int   late;

    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    ce_m    = 1'b0;
    reg_sel = 1'b0;
    cpu_wr  = 1'b0;
    cpu_di  = 8'h00;
    model_reset();
    clear_stats();

    tv[0] = '{di: 8'hC1, exp_hi: 8'hC1, exp_do: 8'hC1, gap_at: 0};
    tv[1] = '{di: 8'hFE, exp_hi: 8'hDE, exp_do: 8'hFE, gap_at: 0};
    tv[2] = '{di: 8'hFF, exp_hi: 8'hDF, exp_do: 8'hFF, gap_at: 40};
    tv[3] = '{di: 8'hE0, exp_hi: 8'hC0, exp_do: 8'hE0, gap_at: 0};
    tv[4] = '{di: 8'hDF, exp_hi: 8'hDF, exp_do: 8'hDF, gap_at: 100};
    tv[5] = '{di: 8'h00, exp_hi: 8'h00, exp_do: 8'h00, gap_at: 0};

    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    reset_n = 1'b1;

    // Strobes without a full FF46 decode must not start anything.
    repeat (4) tick(1'b1, 1'b0, 1'b1, 8'h77);
    tick(1'b1, 1'b1, 1'b0, 8'h66);
    chk("no_decode_cpu_do", cpu_do, 0);
    chk("no_decode_idle", dma_active, 0);

    for (int v = 0; v < 6; v++) begin
      clear_stats();
      tick(1'b1, 1'b1, 1'b1, tv[v].di);
      chk("m1_no_read", dma_rd, 0);
      chk("m1_unlocked", dma_active, 0);
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      chk("e1_locked", dma_active, 1);
      chk("e1_first_addr", dma_src_addr, {tv[v].exp_hi, 8'h00});
      for (int c = 2; c <= 161; c++) begin
        if (c == tv[v].gap_at) begin
          src0 = dma_src_addr;
          w0   = wr_cnt;
          repeat (5) tick(1'b0, 1'b1, 1'b1, 8'h55);
          chk("gap_src_stable", dma_src_addr, src0);
          chk("gap_no_extra_wr", wr_cnt - w0, 0);
          chk("gap_cpu_do", cpu_do, tv[v].exp_do);
        end
        tick(1'b1, 1'b0, 1'b0, 8'h00);
      end
      chk("last_wr_pulse", oam_wr, 1);
      chk("last_wr_addr", oam_addr, OAM_BYTES - 1);
      chk("last_wr_locked", dma_active, 1);
      chk("last_no_read", dma_rd, 0);
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      chk("end_unlocked", dma_active, 0);
      chk("wr_count", wr_cnt, OAM_BYTES);
      chk("first_src", first_src, {16'h0, tv[v].exp_hi, 8'h00});
      chk("last_src", last_src, {16'h0, tv[v].exp_hi, 8'h9F});
      chk("readback", cpu_do, tv[v].exp_do);
    end

    // Restart mid-transfer: 0x80 at E0, 0x90 at E50.
    clear_stats();
    tick(1'b1, 1'b1, 1'b1, 8'h80);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    watch_act = 1'b1;
    for (int c = 2; c <= 49; c++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b1, 8'h90);
    chk("restart_locked", dma_active, 1);
    chk("restart_no_read", dma_rd, 0);
    chk("restart_pending_wr", oam_wr, 1);
    chk("restart_pending_addr", oam_addr, 48);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_first_addr", dma_src_addr, 16'h9000);
    for (int c = 52; c <= 211; c++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    watch_act = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_no_gap", act_dropped, 0);
    chk("restart_old_reads", rd_cnt[8'h80], 49);
    chk("restart_new_reads", rd_cnt[8'h90], OAM_BYTES);
    chk("restart_wr_total", wr_cnt, 49 + OAM_BYTES);
    chk("restart_end_unlocked", dma_active, 0);

    // Write on the same edge as the final capture.
    clear_stats();
    tick(1'b1, 1'b1, 1'b1, 8'hC1);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    watch_act = 1'b1;
    for (int c = 2; c <= 160; c++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b1, 8'h80);
    chk("edge_final_wr", oam_wr, 1);
    chk("edge_final_addr", oam_addr, 159);
    chk("edge_final_data", oam_di, 8'h5E);
    chk("edge_locked", dma_active, 1);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("edge_new_first", dma_src_addr, 16'h8000);
    for (int c = 163; c <= 322; c++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    watch_act = 1'b0;
    chk("edge_new_last_addr", oam_addr, 159);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("edge_no_gap", act_dropped, 0);
    chk("edge_wr_total", wr_cnt, 2 * OAM_BYTES);
    chk("edge_new_reads", rd_cnt[8'h80], OAM_BYTES);

    // Write into a fresh setup stays unlocked; into a restarted setup stays locked.
    tick(1'b1, 1'b1, 1'b1, 8'h44);
    tick(1'b1, 1'b1, 1'b1, 8'h45);
    chk("fresh_rewrite_unlocked", dma_active, 0);
    chk("fresh_rewrite_no_read", dma_rd, 0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("fresh_rewrite_src", dma_src_addr, 16'h4500);
    repeat (10) tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b1, 8'h46);
    tick(1'b1, 1'b1, 1'b1, 8'h47);
    chk("restart_rewrite_locked", dma_active, 1);
    chk("restart_rewrite_no_read", dma_rd, 0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_rewrite_src", dma_src_addr, 16'h4700);
    repeat (165) tick(1'b1, 1'b0, 1'b0, 8'h00);

    // Reset at M-cycle 80: bytes 0..78 are in OAM, nothing after.
    clear_stats();
    tick(1'b1, 1'b1, 1'b1, 8'h12);
    for (int c = 1; c <= 80; c++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("prereset_wr", oam_wr, 1);
    chk("prereset_addr", oam_addr, 78);
    apply_reset();
    repeat (4) tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("postreset_wr_total", wr_cnt, 79);
    for (int k = 0; k <= 78; k++)
      chk("reset_oam_keep", {written[k], mem[k]}, {1'b1, 8'(k) ^ 8'h12});
    late = 0;
    for (int k = 79; k < OAM_BYTES; k++) if (written[k]) late++;
    chk("reset_no_late_wr", late, 0);

    // Randomized FF46 traffic, ce_m gaps and occasional resets against the model.
    for (int i = 0; i < 6000; i++) begin
      rce = ($urandom_range(0, 9) != 0);
      r   = $urandom_range(0, 299);
      rdi = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(224, 255)) : 8'($urandom);
      if ($urandom_range(0, 2999) == 0) apply_reset();
      if (r < 2)       tick(rce, 1'b1, 1'b1, rdi);
      else if (r < 6)  tick(rce, 1'b1, 1'b0, rdi);
      else if (r < 10) tick(rce, 1'b0, 1'b1, rdi);
      else             tick(rce, 1'b0, 1'b0, rdi);
    end
    repeat (170) tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("final_idle", dma_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA controller for the GB/GBC core. It sequences the 160-byte copy triggered by a CPU write to FF46 from the system bus into sprite attribute memory. It drives the `dma_active` lock that the sprite unit uses to take OAM away from the CPU, OAM evaluation and sprite fetch. It sits between the CPU register decode, the bus mux (DMA read port) and the sprite unit's OAM write port.

## Interface
Parameters:
- `OAM_BYTES`, default 160: bytes per transfer; last index is `OAM_BYTES-1`.
- `SETUP_MCYC`, default 1: M-cycles between the FF46 write and the first read.

Ports:
- `clk` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_m` in 1: one-clock pulse per CPU M-cycle. All state advances only on clocks with `ce_m`=1.
- `reg_sel` in 1: CPU address decodes to FF46.
- `cpu_wr` in 1: CPU write strobe, sampled with `ce_m`.
- `cpu_di` in 8: CPU write data.
- `cpu_do` out 8: FF46 readback, i.e. the last written value.
- `dma_rd` out 1: DMA owns the external bus this M-cycle.
- `dma_src_addr` out 16: bus read address.
- `dma_rd_data` in 8: bus read data, valid at the `ce_m` clock that ends the M-cycle.
- `dma_active` out 1: OAM locked for DMA; drives the sprite unit's `dma_active`.
- `oam_wr` out 1: single-clock OAM write strobe.
- `oam_addr` out 8: OAM write index, 0..159.
- `oam_di` out 8: OAM write data.

## Operation
States:
- IDLE: no transfer pending.
- SETUP: counts `SETUP_MCYC` M-cycles.
- XFER: copies one byte per M-cycle.

Source high byte:
- `src_hi` is latched from `cpu_di` on every accepted write (`reg_sel & cpu_wr & ce_m`).
- Values 0xE0..0xFF fold to `src_hi - 0x20`, so FE/FF read the DE/DF echo. `cpu_do` returns the unfolded value.

Transitions (all on `ce_m` clocks):
- Any state, on an accepted write: go to SETUP, set `setup_cnt = SETUP_MCYC`, clear `idx` to 0. If the previous state was XFER or SETUP-restart, set `restart` = 1.
- SETUP: decrement `setup_cnt`. When it reaches 0, go to XFER with `idx` = 0 and clear `restart`.
- XFER: capture `dma_rd_data` into `oam_di`, set `oam_addr` to `idx`, arm `wr_pend`, then increment `idx`. When `idx` = `OAM_BYTES-1`, go to IDLE after the capture.

Outputs:
- `dma_src_addr` = {`src_hi_folded`, `idx`}. `idx` is 8 bits and never exceeds 159; there is no wrap.
- `dma_rd` = (state == XFER).
- `oam_wr` = `wr_pend`, held for exactly one `clk` (the clock after the capture) regardless of `ce_m`.
- `dma_active` = (state == XFER) | `wr_pend` | (state == SETUP & `restart`). A restarted transfer keeps OAM locked with no gap; a fresh start does not lock OAM during setup.

Simultaneous events:
- A write on the same `ce_m` as the last XFER capture: the capture and its `oam_wr` still occur, then the controller goes to SETUP with `restart` = 1.
- A write during SETUP restarts the setup count. `restart` is kept.

## Timing
Reset values, applied immediately on `reset_n` low regardless of `clk`:
- state = IDLE, `idx` = 0, `setup_cnt` = 0, `restart` = 0, `wr_pend` = 0.
- `cpu_do` = 0x00, `src_hi` = 0x00.
- `oam_addr` = 0, `oam_di` = 0.
- All strobes and `dma_active` = 0.

Cycle sequence, with the FF46 write accepted at M-cycle edge E0:
- SETUP covers M-cycle 1.
- At E1 the state enters XFER.
- M-cycles 2..161 present bytes 0..159.
- Captures happen at E2..E161. `oam_wr` fires one clock after each capture.
- IDLE from E161.
- `dma_active` rises at E1 and falls one clock after E161.

Reset mid-transfer:
- Aborts immediately. No further `oam_wr` is issued; bytes already written stay in OAM.

`ce_m` low:
- Everything is frozen except the single pending `oam_wr` clock.

## Test plan
- Write 0xC1 at E0 with a bus model returning the low byte of the address. Require 160 `oam_wr` pulses with `oam_addr` = k and `oam_di` = k, source addresses 0xC100..0xC19F, `dma_active` high from E1 through E161+1 clk, and no read at M1.
- Write 0xFE. Require source addresses 0xDE00..0xDE9F and `cpu_do` = 0xFE.
- Write 0x80, then write 0x90 at E50 (mid-XFER). Require the 0x90 transfer to start at E51+1 with `idx` = 0, `dma_active` never to drop, and exactly 49 writes from 0x80xx.
- Write 0x80 on the same edge as capture 159. Require the final `oam_wr` (`oam_addr` = 159) to occur, followed by a full new 160-byte transfer with no `dma_active` gap.
- Assert `reset_n` low at M-cycle 80. Require all outputs at reset values in the same clock, no further `oam_wr`, and OAM[0..78] retaining their written data.
- Hold `ce_m` low for 5 clocks mid-XFER. Require `idx` and `dma_src_addr` stable, only the one pending `oam_wr`, then normal resumption.
